// File: rtl/connect_pixel_streamer.sv
// connect_pixel_streamer: producer end of the connect-layer pixel interface.
// Buffers one FRAME_LEN-pixel frame of 3-channel pixels and replays it as a
// cnt/in_vld/data_c0..c2 beat stream for the 3x3 inner-dot consumers.
// Build option: define CONNECT_STREAMER_PINGPONG_EN for two ping-pong banks
// (write of the next frame overlaps streaming of the current one); when it is
// undefined a single bank is used and writes stall until the frame has streamed.
module connect_pixel_streamer #(
  parameter int FRAME_LEN = 68,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_vld,
  output logic                wr_rdy,
  input  logic [3*DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]    cnt,
  output logic                in_vld,
  output logic [DATA_W-1:0]   data_c0,
  output logic [DATA_W-1:0]   data_c1,
  output logic [DATA_W-1:0]   data_c2,
  output logic                frame_done
);

`ifdef CONNECT_STREAMER_PINGPONG_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int AW = $clog2(NBANK * FRAME_LEN);
  localparam int PW = 3 * DATA_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  // Banks are laid out back to back: bank b, pixel i lives at b*FRAME_LEN + i.
  logic [PW-1:0]    mem [NBANK*FRAME_LEN];
  logic [1:0]       full;
  logic [CNT_W-1:0] wp;
  logic             wb;
  logic             rb;
  logic [0:0]       state;

  logic             wr_fire;
  logic             wr_last;
  logic             rd_last;
  logic             other_ready;
  logic             next_bank;
  logic [CNT_W-1:0] rd_idx;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [PW-1:0]    rd_word;

  // Handshake, addressing and next-beat selection.
  always_comb begin
    wr_rdy  = !rst && !full[wb];
    wr_fire = wr_vld && wr_rdy;
    wr_last = (wp == LAST);
    wr_addr = AW'(wp) + (wb ? AW'(FRAME_LEN) : AW'(0));
    rd_last = (state == S_STREAM) && (cnt == LAST);
`ifdef CONNECT_STREAMER_PINGPONG_EN
    // A frame completing in the other bank on this very edge counts as ready,
    // so the stream continues without a gap.
    other_ready = full[~rb] || (wr_fire && wr_last && (wb != rb));
    next_bank   = rd_last ? ~rb : rb;
`else
    other_ready = 1'b0;
    next_bank   = rb;
`endif
    rd_idx  = (state == S_STREAM && !rd_last) ? cnt + CNT_W'(1) : '0;
    rd_addr = AW'(rd_idx) + (next_bank ? AW'(FRAME_LEN) : AW'(0));
    rd_word = mem[rd_addr];
  end

  // Pixel storage; contents need no reset because the full flags gate use.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= wr_data;
  end

  // Write pointer and write-bank select.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      wb <= 1'b0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wp <= '0;
`ifdef CONNECT_STREAMER_PINGPONG_EN
        wb <= ~wb;
`endif
      end else begin
        wp <= wp + CNT_W'(1);
      end
    end
  end

  // Per-bank full flags: set on the last write, cleared on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      for (int unsigned b = 0; b < 2; b++) begin
        if (wr_fire && wr_last && (wb == b[0])) full[b] <= 1'b1;
        else if (rd_last && (rb == b[0]))       full[b] <= 1'b0;
      end
    end
  end

  // Read FSM with registered stream outputs; idle outputs are held at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rb         <= 1'b0;
      cnt        <= '0;
      in_vld     <= 1'b0;
      data_c0    <= '0;
      data_c1    <= '0;
      data_c2    <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= '0;
      in_vld     <= 1'b0;
      data_c0    <= '0;
      data_c1    <= '0;
      data_c2    <= '0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (full[rb]) begin
            state   <= S_STREAM;
            in_vld  <= 1'b1;
            data_c0 <= rd_word[DATA_W-1:0];
            data_c1 <= rd_word[2*DATA_W-1:DATA_W];
            data_c2 <= rd_word[3*DATA_W-1:2*DATA_W];
          end
        end
        default: begin
          if (rd_last) begin
`ifdef CONNECT_STREAMER_PINGPONG_EN
            rb <= ~rb;
`endif
            if (other_ready) begin
              in_vld  <= 1'b1;
              data_c0 <= rd_word[DATA_W-1:0];
              data_c1 <= rd_word[2*DATA_W-1:DATA_W];
              data_c2 <= rd_word[3*DATA_W-1:2*DATA_W];
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt        <= cnt + CNT_W'(1);
            in_vld     <= 1'b1;
            data_c0    <= rd_word[DATA_W-1:0];
            data_c1    <= rd_word[2*DATA_W-1:DATA_W];
            data_c2    <= rd_word[3*DATA_W-1:2*DATA_W];
            frame_done <= ((cnt + CNT_W'(1)) == LAST);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/connect_pixel_streamer.md
# connect_pixel_streamer

Producer end of the connect-layer pixel interface: accepts 3-channel pixels from the line-shift fetch path, buffers one 68-beat frame, and replays it as a `cnt`/`in_vld`/`data_c0..c2` beat stream. The stream feeds the 3×3 inner-dot consumers, which key accumulate-clear and tap selection purely on `cnt`. Ping-pong banks let the next frame be written while the current one streams.

## Interface
- `FRAME_LEN`, 68: beats per frame; `cnt` runs 0..FRAME_LEN-1.
- `DATA_W`, 8: bits per channel.
- `CNT_W`, `$clog2(FRAME_LEN)`: `cnt` width (7 at default).

- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `wr_vld`  in  1  upstream pixel valid.
- `wr_rdy`  out  1  streamer can accept a pixel.
- `wr_data`  in  3*DATA_W  {c2,c1,c0}; c0 in LSBs.
- `cnt`  out  CNT_W  beat index within frame.
- `in_vld`  out  1  current beat carries frame data.
- `data_c0` / `data_c1` / `data_c2`  out  DATA_W each  channel values for pixel `cnt`.
- `frame_done`  out  1  one-cycle pulse coincident with beat `cnt==FRAME_LEN-1`.

## Operation
- Storage: two banks × FRAME_LEN × 3*DATA_W registers; per-bank `full` flag; write pointer `wp`, bank selects `wb`, `rb`.
- Write: accept when `wr_vld && wr_rdy`; store at `bank[wb][wp]`, `wp++`. On accept at `wp==FRAME_LEN-1`: set `full[wb]`, `wp<=0`, toggle `wb`.
- `wr_rdy = !rst && !full[wb]` (combinational).
- Read FSM: IDLE, STREAM.
  - IDLE: `in_vld=0`, `cnt=0`, data 0. If `full[rb]` → STREAM, first beat `cnt=0` next cycle.
  - STREAM: each cycle one beat, `in_vld=1`, `cnt` 0,1,…,FRAME_LEN-1, `data_cX = bank[rb][cnt].cX`. At last beat: clear `full[rb]`, toggle `rb`, pulse `frame_done`; if other bank already `full` → next cycle `cnt=0` (back-to-back, no gap); else → IDLE.
- No backpressure from consumer; stream never stalls mid-frame.
- Simultaneous: write filling bank X and read releasing bank Y same cycle both take effect; flags are per-bank, no conflict. A bank released on last beat is writable the following cycle.
- Frames emitted in write order; every frame exactly FRAME_LEN beats.

## Timing
- Reset values: `cnt=0`, `in_vld=0`, `data_c0..c2=0`, `frame_done=0`, `wr_rdy=0` while `rst` high; `wp=0`, `wb=rb=0`, both `full=0`.
- All stream outputs registered.
- Latency: 68th pixel accepted at edge N → beat `cnt=0` valid in cycle N+1 (when streamer idle).
- Frame occupies exactly FRAME_LEN consecutive `in_vld` cycles.
- `rst` mid-frame: next cycle all outputs at reset values; buffered pixels discarded; partial frame never resumed.
- Idle `cnt` held at 0 so downstream `cnt`-decoded clears never fire spuriously.

## Configuration
- `CONNECT_STREAMER_PINGPONG_EN` defined: two banks as above; write and stream overlap.
- Undefined: single bank; `wb`/`rb` fixed 0; `wr_rdy` low from 68th accept through last streamed beat, high the cycle after; frames separated by ≥FRAME_LEN write cycles.

## Test plan
- Reset: hold `rst` 3 cycles with `wr_vld=1` → `wr_rdy=0`, `in_vld=0`, `cnt=0`, data 0, nothing stored.
- Single frame: write pixel i as c0=i, c1=i+100, c2=255-i, i=0..67 → 68 beats, `cnt=i`, `data_c1=i+100`, first beat one cycle after last accept, `frame_done` only at `cnt=67`.
- Back-to-back: continuous `wr_vld` for 3 frames (PINGPONG on) → `in_vld` high 204 cycles with no gap after first; `cnt` wraps 67→0.
- Backpressure: write 136 pixels before first frame completes → `wr_rdy` low after 136th accept, high the cycle after `frame_done`.
- Reset at `cnt=40` → next cycle `in_vld=0`, `cnt=0`; new frame after reset streams from its own pixel 0.
- Macro undefined: write 68 then keep `wr_vld=1` → `wr_rdy` low for cycles through `cnt=67`, first second-frame accept the cycle after `frame_done`.
